// File: rtl/vga_pkg.sv
// Raster timing shared by the VGA timing generator and the game/pixel decoder.
package vga_pkg;

  typedef struct packed {
    int   pixel_x_bits;
    int   pixel_y_bits;
    int   h_active;
    int   h_fp;
    int   h_sync;
    int   h_bp;
    int   h_total;
    int   v_active;
    int   v_fp;
    int   v_sync;
    int   v_bp;
    int   v_total;
    logic sync_pol;
  } vga_params_t;

  // 640x480@60, negative sync pulses
  localparam vga_params_t VGA_DEFAULT = '{
    pixel_x_bits: 10, pixel_y_bits: 10,
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48, h_total: 800,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33, v_total: 525,
    sync_pol: 1'b0
  };

  function automatic logic in_window(int v, int start, int len);
    return (v >= start) && (v < start + len);
  endfunction

endpackage

// File: rtl/vga_mod_counter.sv
// Modulo-MOD up-counter; wrap flags the enabled step from MOD-1 back to 0.
module vga_mod_counter #(
  parameter int MOD   = 800,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q, count_d;

  assign wrap  = en && (int'(count_q) == MOD - 1);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (wrap) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_timing_generator.sv
// Free-running VGA raster: issues the next pixel coordinate to the decoder and
// registers its pixel value together with the sync/blanking outputs.
module vga_timing_generator
  import vga_pkg::*;
#(
  parameter vga_params_t params = VGA_DEFAULT,
  localparam int XW = params.pixel_x_bits,
  localparam int YW = params.pixel_y_bits
) (
  input  logic          clk,
  input  logic          reset,
  output logic [XW-1:0] pixel_x_target_next,
  output logic [YW-1:0] pixel_y_target_next,
  input  logic          pixel_value_next,
  output logic          pixel_out,
  output logic          h_sync,
  output logic          v_sync,
  output logic          video_on,
  output logic          frame_start
);

  localparam int   HA = params.h_active;
  localparam int   HT = params.h_total;
  localparam int   VA = params.v_active;
  localparam int   VT = params.v_total;
  localparam logic SP = params.sync_pol;

  if ((longint'(1) << XW) < longint'(HT)) begin : g_bad_x_width
    $error("pixel_x_bits too narrow for h_total");
  end
  if ((longint'(1) << YW) < longint'(VT)) begin : g_bad_y_width
    $error("pixel_y_bits too narrow for v_total");
  end
  if (HT != HA + params.h_fp + params.h_sync + params.h_bp) begin : g_bad_h_total
    $error("h_total does not match the sum of the horizontal intervals");
  end
  if (VT != VA + params.v_fp + params.v_sync + params.v_bp) begin : g_bad_v_total
    $error("v_total does not match the sum of the vertical intervals");
  end

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic          h_wrap, v_wrap;

  vga_mod_counter #(.MOD(HT), .WIDTH(XW)) u_h_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  vga_mod_counter #(.MOD(VT), .WIDTH(YW)) u_v_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (h_wrap),
    .count (v_cnt),
    .wrap  (v_wrap)
  );

  assign pixel_x_target_next = h_cnt;
  assign pixel_y_target_next = v_cnt;

  int   h_i, v_i;
  logic video_on_d, pixel_d, h_sync_d, v_sync_d, frame_start_d;
  logic video_on_q, pixel_q, h_sync_q, v_sync_q, frame_start_q;
  // Counters sit at (0,0) exactly after reset or after a frame wrap.
  logic origin_q;

  always_comb begin
    h_i           = int'(h_cnt);
    v_i           = int'(v_cnt);
    video_on_d    = (h_i < HA) && (v_i < VA);
    pixel_d       = pixel_value_next && video_on_d;
    h_sync_d      = in_window(h_i, HA + params.h_fp, params.h_sync) ? SP : ~SP;
    v_sync_d      = in_window(v_i, VA + params.v_fp, params.v_sync) ? SP : ~SP;
    frame_start_d = origin_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      video_on_q    <= 1'b0;
      pixel_q       <= 1'b0;
      h_sync_q      <= ~SP;
      v_sync_q      <= ~SP;
      frame_start_q <= 1'b0;
      origin_q      <= 1'b1;
    end else begin
      video_on_q    <= video_on_d;
      pixel_q       <= pixel_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      frame_start_q <= frame_start_d;
      origin_q      <= v_wrap;
    end
  end

  assign video_on    = video_on_q;
  assign pixel_out   = pixel_q;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench: full 640x480 instance for line-level timing, plus a
// scaled-down raster instance so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_timing_generator;
  import vga_pkg::*;

  localparam vga_params_t SMALL_P = '{
    pixel_x_bits: 6, pixel_y_bits: 5,
    h_active: 20, h_fp: 4, h_sync: 6, h_bp: 3, h_total: 33,
    v_active: 10, v_fp: 3, v_sync: 2, v_bp: 4, v_total: 19,
    sync_pol: 1'b0
  };

  // index 0: 640x480 instance, index 1: scaled instance
  localparam int HT_C  [2] = '{800, 33};
  localparam int HA_C  [2] = '{640, 20};
  localparam int HSS_C [2] = '{656, 24};
  localparam int HSL_C [2] = '{96, 6};
  localparam int VT_C  [2] = '{525, 19};
  localparam int VA_C  [2] = '{480, 10};
  localparam int VSS_C [2] = '{490, 13};
  localparam int VSL_C [2] = '{2, 2};

  logic       clk = 1'b0;
  logic       rst_v [2];
  logic       pv    [2];
  logic [9:0] x0, y0;
  logic [5:0] x1;
  logic [4:0] y1;
  logic       po [2], hs [2], vs [2], vo [2], fs [2];

  always #5 clk = ~clk;

  vga_timing_generator u_dut (
    .clk                 (clk),
    .reset               (rst_v[0]),
    .pixel_x_target_next (x0),
    .pixel_y_target_next (y0),
    .pixel_value_next    (pv[0]),
    .pixel_out           (po[0]),
    .h_sync              (hs[0]),
    .v_sync              (vs[0]),
    .video_on            (vo[0]),
    .frame_start         (fs[0])
  );

  vga_timing_generator #(.params(SMALL_P)) u_dut_small (
    .clk                 (clk),
    .reset               (rst_v[1]),
    .pixel_x_target_next (x1),
    .pixel_y_target_next (y1),
    .pixel_value_next    (pv[1]),
    .pixel_out           (po[1]),
    .h_sync              (hs[1]),
    .v_sync              (vs[1]),
    .video_on            (vo[1]),
    .frame_start         (fs[1])
  );

  typedef struct {
    int   inst;
    logic vo, po, hs, vs, fs;
  } exp_t;

  exp_t sb_q [$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   pv_mode = 0;
  int   mh [2] = '{0, 0};
  int   mv [2] = '{0, 0};

  int   vo_run [2], hs_run [2], vs_run [2], fs_last [2];
  bit   vo_arm [2], hs_arm [2], vs_arm [2];
  logic vo_p [2], hs_p [2], vs_p [2];
  int   px [2], py [2];

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int dut_x(int i);
    return (i == 0) ? int'(x0) : int'(x1);
  endfunction

  function automatic int dut_y(int i);
    return (i == 0) ? int'(y0) : int'(y1);
  endfunction

  function automatic exp_t predict(int i);
    exp_t e;
    logic act;
    e.inst = i;
    if (rst_v[i]) begin
      e.vo = 1'b0; e.po = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0;
    end else begin
      act  = (mh[i] < HA_C[i]) && (mv[i] < VA_C[i]);
      e.vo = act;
      e.po = pv[i] && act;
      e.hs = !((mh[i] >= HSS_C[i]) && (mh[i] < HSS_C[i] + HSL_C[i]));
      e.vs = !((mv[i] >= VSS_C[i]) && (mv[i] < VSS_C[i] + VSL_C[i]));
      e.fs = (mh[i] == 0) && (mv[i] == 0);
    end
    return e;
  endfunction

  task automatic measure(int i, logic rst_e);
    if (rst_e) begin
      vo_arm[i] = 0; hs_arm[i] = 0; vs_arm[i] = 0; fs_last[i] = -1;
    end else begin
      if (vo[i] && !vo_p[i]) begin vo_arm[i] = 1; vo_run[i] = 0; end
      if (vo[i]) vo_run[i]++;
      if (!vo[i] && vo_p[i] && vo_arm[i])
        check_eq($sformatf("d%0d.video_on_len", i), vo_run[i], HA_C[i]);

      if (!hs[i] && hs_p[i]) begin
        hs_arm[i] = 1; hs_run[i] = 0;
        check_eq($sformatf("d%0d.hsync_start_x", i), px[i], HSS_C[i]);
      end
      if (!hs[i]) hs_run[i]++;
      if (hs[i] && !hs_p[i] && hs_arm[i])
        check_eq($sformatf("d%0d.hsync_len", i), hs_run[i], HSL_C[i]);

      if (!vs[i] && vs_p[i]) begin
        vs_arm[i] = 1; vs_run[i] = 0;
        check_eq($sformatf("d%0d.vsync_start_x", i), px[i], 0);
        check_eq($sformatf("d%0d.vsync_start_y", i), py[i], VSS_C[i]);
      end
      if (!vs[i]) vs_run[i]++;
      if (vs[i] && !vs_p[i] && vs_arm[i])
        check_eq($sformatf("d%0d.vsync_len", i), vs_run[i], VSL_C[i] * HT_C[i]);

      if (fs[i]) begin
        if (fs_last[i] >= 0)
          check_eq($sformatf("d%0d.frame_period", i), cyc - fs_last[i], HT_C[i] * VT_C[i]);
        fs_last[i] = cyc;
      end
    end
    vo_p[i] = vo[i]; hs_p[i] = hs[i]; vs_p[i] = vs[i];
    px[i] = dut_x(i); py[i] = dut_y(i);
  endtask

  task automatic tick();
    exp_t e;
    int   i;
    logic rst_e [2];
    for (int k = 0; k < 2; k++) begin
      case (pv_mode)
        0:       pv[k] = (mh[k] % 2) != 0;
        1:       pv[k] = 1'b1;
        default: pv[k] = 1'($urandom_range(0, 1));
      endcase
      rst_e[k] = rst_v[k];
      sb_q.push_back(predict(k));
    end
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst_e[k]) begin
        mh[k] = 0; mv[k] = 0;
      end else if (mh[k] == HT_C[k] - 1) begin
        mh[k] = 0;
        mv[k] = (mv[k] == VT_C[k] - 1) ? 0 : mv[k] + 1;
      end else begin
        mh[k]++;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      e = sb_q.pop_front();
      i = e.inst;
      check_eq($sformatf("d%0d.video_on", i),    vo[i], e.vo);
      check_eq($sformatf("d%0d.pixel_out", i),   po[i], e.po);
      check_eq($sformatf("d%0d.h_sync", i),      hs[i], e.hs);
      check_eq($sformatf("d%0d.v_sync", i),      vs[i], e.vs);
      check_eq($sformatf("d%0d.frame_start", i), fs[i], e.fs);
      check_eq($sformatf("d%0d.x", i),           dut_x(i), mh[i]);
      check_eq($sformatf("d%0d.y", i),           dut_y(i), mv[i]);
      measure(i, rst_e[i]);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_v[k] = 1'b1; pv[k] = 1'b0;
      vo_run[k] = 0; hs_run[k] = 0; vs_run[k] = 0; fs_last[k] = -1;
      vo_arm[k] = 0; hs_arm[k] = 0; vs_arm[k] = 0;
      vo_p[k] = 1'b0; hs_p[k] = 1'b1; vs_p[k] = 1'b1; px[k] = 0; py[k] = 0;
    end

    repeat (5) tick();
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;

    // alternating pixels, then a full line with the decoder driving 1
    pv_mode = 0;
    repeat (801) tick();
    pv_mode = 1;
    repeat (800) tick();

    pv_mode = 2;
    for (int n = 0; n < 2000 && !(mh[0] == 300 && mv[0] == 2); n++) tick();
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    repeat (800) tick();

    for (int n = 0; n < 1000 && !(mh[1] == 15 && mv[1] == 7); n++) tick();
    rst_v[1] = 1'b1;
    tick();
    rst_v[1] = 1'b0;
    repeat (700) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
